conv_layer_kernel_accumulator: RTL and testbench
================================================

# conv_layer_kernel_accumulator

Downstream stage of the conv layer's pixel input cache. It consumes the 6-lane pixel vector the cache presents for each of the 9 taps of a 3x3 kernel. For each tap it multiplies all lanes by the tap weight, read from an asynchronous weight ROM, and accumulates per lane. After 9 taps it emits one 6-pixel output row. Six rows form one 6x6 output frame, computed from an 8x8 input.

## Interface
- DATA_W, 32: pixel/weight width, signed Q16.16
- LANES, 6: pixels per vector
- TAPS, 9: kernel taps per output row
- ROWS, 6: output rows per frame
- clk  in  1: clock, rising edge
- rst_n  in  1: reset, asynchronous and active-low
- enable  in  1: run request; low pauses accumulation
- in_kernel_port  in  192: 6 pixels; lane 0 in bits [191:160], lane 5 in bits [31:0]
- in_valid  in  1: in_kernel_port holds the current tap
- in_ready  out  1: block accepts a tap this cycle
- weight_addr  out  4: tap index 0..8 to the weight ROM
- weight_in  in  32: ROM data for weight_addr, same cycle (combinational ROM)
- out_row_port  out  192: 6 results, same lane packing as the input
- out_valid  out  1: single-cycle row-valid pulse
- out_row_index  out  3: row number 0..5 of out_row_port
- frame_done  out  1: pulse coincident with out_valid of row 5
- current_state  out  3: FSM state, for debug

## Operation
- FSM states:
  - S_IDLE = 3'd0
  - S_ACC = 3'd1
  - S_OUT = 3'd2
  - all other codes go to S_IDLE.
- S_IDLE:
  - Clears the tap counter, the row counter and all accumulators.
  - Moves to S_ACC when enable=1.
- S_ACC:
  - in_ready = 1.
  - A beat is accepted when in_valid & enable.
  - On each accepted beat, every lane does acc[i] += pixel[i] * weight_in.
  - The tap counter then increments.
  - Accepting tap 8 moves the FSM to S_OUT.
  - With no beat accepted, all state holds.
- S_OUT:
  - in_ready = 0; input is ignored.
  - out_valid = 1, and out_row_index = the row counter.
  - Accumulators and the tap counter clear.
  - If the row counter is 5: frame_done = 1, the row counter resets to 0, and the FSM goes to S_IDLE.
  - Otherwise the row counter increments and the FSM goes to S_ACC.
- weight_addr = the tap counter, in every state.
- Arithmetic:
  - Product: 32x32 signed gives 64 bits, Q32.32.
  - Accumulator: 68-bit signed per lane, so no internal overflow is possible.
  - Output: acc >>> 16 (truncate toward minus infinity), then saturate to signed 32 bits.
  - Saturation limits are 0x7FFFFFFF and 0x80000000.
- enable deasserted in S_ACC pauses the row, it does not abort it. Partial sums are kept until enable returns.

## Timing
- Reset values:
  - state S_IDLE
  - counters 0
  - accumulators 0
  - in_ready 0, out_valid 0, frame_done 0
  - out_row_port 0, out_row_index 0
  - weight_addr 0
- Outputs are registered except in_ready and weight_addr, which decode combinationally from state and the tap counter.
- enable rising in S_IDLE: S_ACC on the next edge, so the first beat can be accepted one cycle after enable.
- Minimum row time: 9 accept cycles + 1 S_OUT cycle = 10 cycles. A full frame takes at least 60 cycles, plus 1 idle cycle.
- Latency: out_valid is asserted in the cycle after the edge that accepts tap 8.
- out_row_port holds its value until the next S_OUT.
- Bubbles: in_valid low for any number of cycles inserts the same number of stall cycles, with no data loss.
- Reset mid-row: all partial sums are discarded. After release, the block restarts from tap 0, row 0.

## Configuration
- CONV_KERNEL_RELU_EN:
  - Defined: after saturation, a negative lane result is forced to 32'h0.
  - Undefined: the signed saturated result passes unchanged.
  - Nothing else differs.

## Structure
- Shared package conv_layer_pkg holds:
  - DATA_W, LANES, TAPS, ROWS
  - the state encodings S_IDLE / S_ACC / S_OUT
  - the saturation limits.
- Sub-module conv_layer_mac_lane: one lane's multiply, 68-bit accumulator, clear, and the shift/saturate/ReLU output.
- The top instantiates the lane LANES times. It owns the FSM and the counters.

## Test plan
- All pixels 0x00010000, all weights 0x00010000, 9 contiguous beats -> out_valid one cycle after beat 9; every lane 0x00090000; out_row_index 0.
- Same stimulus with in_valid low for 3 cycles after beat 4 -> identical result; out_valid appears exactly 3 cycles later; weight_addr holds at 4 during the stall.
- Pixels 0x7FFF0000 with weight 0x00010000, and lane 5 pixel 0x80000000 -> lanes 0..4 give 0x7FFFFFFF; lane 5 gives 0x80000000 (macro undefined).
- Weight 0xFFFF0000, pixel 0x00010000 -> every lane 0xFFF70000 without CONV_KERNEL_RELU_EN, and 0x00000000 with it.
- 54 back-to-back beats -> six out_valid pulses, out_row_index 0..5; frame_done only with row 5; current_state returns to 0.
- rst_n asserted after tap 5 of row 2, then released, and a fresh row with pixels and weights 0x00010000 -> all outputs 0 during reset; first result 0x00090000 with out_row_index 0.

Source files
------------

// File: rtl/conv_layer_pkg.sv
// Shared constants, state encoding and saturation limits for the conv layer
// kernel accumulator.
package conv_layer_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 6;
  localparam int TAPS   = 9;
  localparam int ROWS   = 6;
  localparam int ACC_W  = 68;
  localparam int FRAC_W = 16;

  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_OUT  = 3'd2
  } state_t;

endpackage

// File: rtl/conv_layer_mac_lane.sv
// One lane: Q16.16 multiply, 68-bit accumulate, then shift/saturate into a held
// result register. Negative results clamp to zero when CONV_KERNEL_RELU_EN is defined.
module conv_layer_mac_lane
  import conv_layer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              capture,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    shifted;
  logic        [DATA_W-1:0]   sat_val;
  logic        [DATA_W-1:0]   final_val;

  assign product = $signed(pixel) * $signed(weight);
  assign acc_sum = acc + $signed({{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product});
  assign shifted = acc_sum >>> FRAC_W;

  // The value fits in 32 signed bits only when bits [67:31] are all equal.
  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:DATA_W-1])) begin
      sat_val = SAT_MAX;
    end else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:DATA_W-1])) begin
      sat_val = SAT_MIN;
    end
  end

`ifdef CONV_KERNEL_RELU_EN
  assign final_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign final_val = sat_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_sum;
    end
  end

  // Capture uses acc_sum so the last tap's product is included in the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (accept && capture) begin
      result <= final_val;
    end
  end

endmodule

// File: rtl/conv_layer_kernel_accumulator.sv
// 3x3 kernel accumulator: 9 taps of a 6-lane pixel vector per output row, 6 rows
// per frame. Optional ReLU on the outputs via CONV_KERNEL_RELU_EN.
module conv_layer_kernel_accumulator
  import conv_layer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [LANES*DATA_W-1:0] in_kernel_port,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [3:0]              weight_addr,
  input  logic [DATA_W-1:0]       weight_in,
  output logic [LANES*DATA_W-1:0] out_row_port,
  output logic                    out_valid,
  output logic [2:0]              out_row_index,
  output logic                    frame_done,
  output logic [2:0]              current_state
);

  // Handshake: a tap transfers on a rising edge where in_valid, in_ready and
  // enable are all high; in_ready is high only in S_ACC and never depends on in_valid.
  state_t     state;
  logic [3:0] tap_cnt;
  logic [2:0] row_cnt;
  logic       accept;
  logic       last_tap;
  logic       lane_clear;

  assign in_ready      = (state == S_ACC);
  assign weight_addr   = tap_cnt;
  assign accept        = in_ready && in_valid && enable;
  assign last_tap      = (tap_cnt == LAST_TAP);
  assign lane_clear    = (state != S_ACC);
  assign current_state = state;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    conv_layer_mac_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (lane_clear),
      .accept  (accept),
      .capture (last_tap),
      .pixel   (in_kernel_port[(LANES-1-g)*DATA_W +: DATA_W]),
      .weight  (weight_in),
      .result  (out_row_port[(LANES-1-g)*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tap_cnt       <= '0;
      row_cnt       <= '0;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      out_row_index <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tap_cnt <= '0;
          row_cnt <= '0;
          if (enable) state <= S_ACC;
        end
        S_ACC: begin
          if (accept) begin
            tap_cnt <= tap_cnt + 4'd1;
            if (last_tap) begin
              out_valid     <= 1'b1;
              out_row_index <= row_cnt;
              frame_done    <= (row_cnt == LAST_ROW);
              state         <= S_OUT;
            end
          end
        end
        S_OUT: begin
          tap_cnt <= '0;
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            row_cnt <= row_cnt + 3'd1;
            state   <= S_ACC;
          end
        end
        default: begin
          tap_cnt <= '0;
          row_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_kernel_accumulator.sv
// Bench for conv_layer_kernel_accumulator: directed rows plus randomized rows
// checked against an arithmetic reference model; honours CONV_KERNEL_RELU_EN.
module tb_conv_layer_kernel_accumulator;

`ifdef CONV_KERNEL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [191:0] in_kernel_port;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   weight_addr;
  logic [31:0]  weight_in;
  logic [191:0] out_row_port;
  logic         out_valid;
  logic [2:0]   out_row_index;
  logic         frame_done;
  logic [2:0]   current_state;

  conv_layer_kernel_accumulator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .in_kernel_port (in_kernel_port),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .weight_addr    (weight_addr),
    .weight_in      (weight_in),
    .out_row_port   (out_row_port),
    .out_valid      (out_valid),
    .out_row_index  (out_row_index),
    .frame_done     (frame_done),
    .current_state  (current_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus storage and weight ROM ----------------
  logic [31:0] pix [9][6];
  logic [31:0] rom [9];
  int          row_num = 0;

  assign weight_in = (weight_addr < 4'd9) ? rom[weight_addr] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [191:0] exp_q [$];
  int           idx_q [$];
  logic         fd_q  [$];
  int           cyc_q [$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum of Q16.16 products, rescale, clamp to int32.
  function automatic logic [31:0] ref_lane(input int lane);
    logic signed [67:0] sum;
    logic signed [67:0] q;
    longint             p;
    logic        [31:0] r;
    sum = '0;
    for (int t = 0; t < 9; t++) begin
      p   = longint'($signed(pix[t][lane])) * longint'($signed(rom[t]));
      sum = sum + p;
    end
    q = sum >>> 16;
    if (q > 68'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (q < -68'sd2147483648) r = 32'h8000_0000;
    else                           r = q[31:0];
    if (RELU && r[31]) r = 32'h0;
    return r;
  endfunction

  function automatic logic [191:0] ref_row();
    logic [191:0] v;
    v = '0;
    for (int l = 0; l < 6; l++) v[191-32*l -: 32] = ref_lane(l);
    return v;
  endfunction

  logic [191:0] mon_row;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done && !out_valid) check("frame_done_alone", frame_done, 1'b0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          mon_row = exp_q.pop_front();
          check("row_data", out_row_port, mon_row);
          check("row_index", out_row_index, idx_q.pop_front());
          check("frame_done", frame_done, fd_q.pop_front());
          check("latency", cyc, cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_val(input int mode);
    logic [31:0] r;
    r = $urandom;
    case (mode)
      0:       return r;
      1:       return {{12{r[19]}}, r[19:0]};
      default: return ($urandom_range(0, 1) == 1) ? r : {{14{r[17]}}, r[17:0]};
    endcase
  endfunction

  task automatic fill_const(input logic [31:0] p, input logic [31:0] w);
    for (int t = 0; t < 9; t++) begin
      rom[t] = w;
      for (int l = 0; l < 6; l++) pix[t][l] = p;
    end
  endtask

  task automatic fill_random();
    int mode;
    mode = $urandom_range(0, 2);
    for (int t = 0; t < 9; t++) begin
      rom[t] = rand_val(mode);
      for (int l = 0; l < 6; l++) pix[t][l] = rand_val(mode);
    end
  endtask

  // Presents taps until n_taps are accepted; returns just after the last accept edge.
  task automatic drive_row(input int n_taps, input int stall_at, input int stall_len,
                           input int bubble_pct, input int en_off_pct);
    int           tap;
    int           stalled;
    int           guard;
    logic [191:0] expv;
    tap     = 0;
    stalled = 0;
    guard   = 0;
    expv    = ref_row();
    while (tap < n_taps && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (in_ready) check("weight_addr", weight_addr, tap);
      for (int l = 0; l < 6; l++) in_kernel_port[191-32*l -: 32] = pix[tap][l];
      if (tap == stall_at && stalled < stall_len) begin
        in_valid = 1'b0;
        stalled++;
      end else begin
        in_valid = ($urandom_range(0, 99) >= bubble_pct);
      end
      enable = ($urandom_range(0, 99) >= en_off_pct);
      if (in_ready && in_valid && enable) begin
        if (tap == 8) begin
          exp_q.push_back(expv);
          idx_q.push_back(row_num);
          fd_q.push_back(row_num == 5);
          cyc_q.push_back(cyc + 1);
          row_num = (row_num + 1) % 6;
        end
        tap++;
      end
    end
    if (tap < n_taps) check("row_timeout", tap, n_taps);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_out_row_port", out_row_port, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_weight_addr", weight_addr, 4'd0);
    check("rst_out_row_index", out_row_index, 3'd0);
    check("rst_current_state", current_state, 3'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    in_valid       = 1'b0;
    in_kernel_port = '0;
    fill_const(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Row 0: unit pixels and weights.
    fill_const(32'h0001_0000, 32'h0001_0000);
    drive_row(9, -1, 0, 0, 0);
    check("ones_lane0", out_row_port[191:160], 32'h0009_0000);
    check("ones_lane5", out_row_port[31:0], 32'h0009_0000);

    // Row 1: same data, three bubble cycles after the fourth beat.
    drive_row(9, 4, 3, 0, 0);
    check("stall_lane2", out_row_port[127:96], 32'h0009_0000);

    // Row 2: saturation in both directions.
    fill_const(32'h7FFF_0000, 32'h0001_0000);
    for (int t = 0; t < 9; t++) pix[t][5] = 32'h8000_0000;
    drive_row(9, -1, 0, 0, 0);
    check("sat_pos_lane0", out_row_port[191:160], 32'h7FFF_FFFF);
    check("sat_neg_lane5", out_row_port[31:0], RELU ? 32'h0 : 32'h8000_0000);

    // Row 3: negative result.
    fill_const(32'h0001_0000, 32'hFFFF_0000);
    drive_row(9, -1, 0, 0, 0);
    check("neg_lane3", out_row_port[95:64], RELU ? 32'h0 : 32'hFFF7_0000);

    // Rows 4-5 complete the frame; then the FSM should fall back to idle.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      drive_row(9, -1, 0, 0, 0);
    end
    enable = 1'b0;
    @(negedge clk);
    check("in_ready_in_out", in_ready, 1'b0);
    check("state_out", current_state, 3'd2);
    @(negedge clk);
    check("state_idle_after_frame", current_state, 3'd0);

    // Randomized rows with bubbles and enable pauses.
    for (int r = 0; r < 14; r++) begin
      fill_random();
      drive_row(9, -1, 0, $urandom_range(0, 40), $urandom_range(0, 25));
    end

    // Partial row 2, then reset in the middle of it.
    fill_random();
    drive_row(6, -1, 0, 0, 0);
    check("queue_empty_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    row_num = 0;
    enable  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    fill_const(32'h0001_0000, 32'h0001_0000);
    drive_row(9, -1, 0, 0, 0);
    check("after_reset_lane0", out_row_port[191:160], 32'h0009_0000);
    check("after_reset_index", out_row_index, 3'd0);

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
